decoder_2to4_encoder: RTL and testbench
=======================================

# decoder_2to4_encoder

Registered 4:2 encoder: the inverse of the team's 2:4 one-hot decoder. Accepts a one-hot word `n` and its active-low complement `p`, checks them for consistency, and returns the 2-bit index `{a,b}` through a one-entry valid/ready output stage. Malformed codes are flagged per transfer and counted. Used as the loop-back/check partner of the decoder in the test harness and wherever a one-hot select must be folded back to binary.

## Interface
- `CW`, default 8: width of the error counter.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous reset, active-high.
- `in_valid`  in  1  `n`/`p` carry a word.
- `in_ready`  out  1  block accepts the word this cycle.
- `n`  in  4  one-hot code (0001, 0010, 0100 or 1000).
- `p`  in  4  active-low copy; must equal `~n`.
- `out_valid`  out  1  `a`, `b` and `code_err` are valid.
- `out_ready`  in  1  downstream consumes the output.
- `a`  out  1  index MSB.
- `b`  out  1  index LSB.
- `code_err`  out  1  the word in the output register was malformed.
- `err_sticky`  out  1  at least one malformed word since reset/clear.
- `err_count`  out  CW  malformed words accepted, saturating.
- `clr_err`  in  1  clear `err_sticky` and `err_count`.

## Operation
- Encoding: 0001→`{a,b}`=00, 0010→01, 0100→10, 1000→11.
- Word is malformed if `n` is not exactly one-hot, or if `p != ~n`.
- Malformed word: `{a,b}` = index of the highest set bit of `n` (00 if `n`=0000), and `code_err`=1.
- FSM, two states:
  - EMPTY: `out_valid`=0. On accept → FULL.
  - FULL: `out_valid`=1. If `out_ready` and no accept → EMPTY. If `out_ready` and accept → stay FULL with the new word. Otherwise hold.
- `in_ready` = EMPTY or (FULL and `out_ready`).
- A transfer occurs on `in_valid && in_ready`.
- Output register holds `a`, `b` and `code_err` stable while `out_valid && !out_ready`.
- Error counter:
  - increments on each accepted malformed word.
  - saturates at 2^CW−1 and never wraps.
  - `err_sticky` is set on the same edge.
- `clr_err` alone: counter→0, sticky→0.
- `clr_err` on the same cycle as an accepted malformed word: counter→1, sticky→1. The new event is recorded after the clear.
- `clr_err` does not affect the data path or the FSM.

## Timing
- Reset values: state EMPTY, `out_valid`=0, `a`=0, `b`=0, `code_err`=0, `err_sticky`=0, `err_count`=0.
- `in_ready` reads 1 the first cycle after reset deasserts.
- Latency: word accepted at edge k appears on the outputs with `out_valid`=1 after edge k. One cycle.
- Throughput is one word per cycle while `out_ready`=1.
- No combinational path from `n`/`p` to the outputs.
- `in_ready` depends combinationally on `out_ready` only.
- `rst` asserted mid-transfer: the held output is dropped and all registers return to reset values on that edge. Inputs are ignored while `rst`=1.
- Counter update and output update for the same word happen on the same edge.

## Structure
- Package `decoder_pkg` holds:
  - the 2-bit index typedef,
  - the four one-hot code constants (`OH_0`..`OH_3`),
  - the FSM state enum (EMPTY, FULL).
- One combinational sub-module `onehot_check`:
  - inputs `n`, `p`.
  - outputs `idx[1:0]` (highest set bit) and `bad`.
- The top level holds the FSM, the output register and the counter.

## Test plan
- Reset, then present `n`=0100, `p`=1011 with `in_valid`=1 and `out_ready`=1 → next cycle `out_valid`=1, `{a,b}`=10, `code_err`=0. Counter stays 0.
- Stream all four codes back-to-back with `out_ready`=1 → outputs 00, 01, 10, 11 on consecutive cycles. `in_ready` stays 1 throughout.
- Backpressure: `out_ready`=0 after the word 0010 is accepted → `in_ready`=0. `{a,b}`=01 holds for 5 cycles. Raising `out_ready` together with a new word 1000 → next cycle `{a,b}`=11.
- Malformed words:
  - `n`=0110 → `{a,b}`=10, `code_err`=1, `err_count`=1, `err_sticky`=1.
  - `n`=0001 with `p`=1111 → `{a,b}`=00, `code_err`=1, `err_count`=2.
  - `n`=0000 → `{a,b}`=00, `code_err`=1, `err_count`=3.
- `CW`=2: feed 5 malformed words → `err_count` sticks at 3. `clr_err` on the same cycle as a 6th malformed word → `err_count`=1.
- Assert `rst` while FULL with `out_ready`=0 → after the edge, `out_valid`=0, `{a,b}`=00, `err_count`=0, `in_ready`=1 after `rst` deasserts.

Source files
------------

// File: rtl/decoder_2to4_encoder_pkg.sv
// Shared types for the registered 4:2 one-hot encoder: index type, one-hot code points, FSM states.
package decoder_pkg;

    typedef logic [1:0] idx_t;

    localparam logic [3:0] OH_0 = 4'b0001;
    localparam logic [3:0] OH_1 = 4'b0010;
    localparam logic [3:0] OH_2 = 4'b0100;
    localparam logic [3:0] OH_3 = 4'b1000;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/decoder_2to4_encoder_if.sv
// Input word stream, output index stream and error-reporting signals of the 4:2 encoder.
interface decoder_2to4_encoder_if #(
    parameter int CW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    n;
    logic [3:0]    p;
    logic          out_valid;
    logic          out_ready;
    logic          a;
    logic          b;
    logic          code_err;
    logic          err_sticky;
    logic [CW-1:0] err_count;
    logic          clr_err;

    modport master (
        output in_valid, n, p, out_ready, clr_err,
        input  in_ready, out_valid, a, b, code_err, err_sticky, err_count
    );

    modport slave (
        input  in_valid, n, p, out_ready, clr_err,
        output in_ready, out_valid, a, b, code_err, err_sticky, err_count
    );
endinterface

// File: rtl/decoder_2to4_encoder_onehot_check.sv
// Combinational fold of a one-hot word to its index (highest set bit wins) plus a consistency flag
// against the active-low copy. Latency 0, no flow control.
module onehot_check
    import decoder_pkg::*;
(
    input  logic [3:0] n,
    input  logic [3:0] p,
    output idx_t       idx,
    output logic       bad
);

    logic w_onehot;
    logic w_compl_ok;

    always_comb begin
        idx = 2'd0;
        if (n[3])      idx = 2'd3;
        else if (n[2]) idx = 2'd2;
        else if (n[1]) idx = 2'd1;
    end

    // n is one-hot iff nonzero and clearing its lowest set bit leaves nothing.
    assign w_onehot   = (n != 4'd0) && ((n & (n - 4'd1)) == 4'd0);
    assign w_compl_ok = (p == ~n);
    assign bad        = !w_onehot || !w_compl_ok;

endmodule

// File: rtl/decoder_2to4_encoder.sv
// Registered 4:2 encoder with a one-entry valid/ready output stage and saturating malformed-word counter.
// One cycle latency, full throughput; in_ready depends only on state and out_ready.
module decoder_2to4_encoder
    import decoder_pkg::*;
#(
    parameter int CW = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    decoder_2to4_encoder_if.slave  bus
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_a;
    logic          r_b;
    logic          r_code_err;
    logic          r_err_sticky;
    logic [CW-1:0] r_err_count;

    idx_t          w_idx;
    logic          w_bad;
    logic          w_in_ready;
    logic          w_out_valid;
    logic          w_accept;
    logic          w_err_evt;
    logic [CW-1:0] w_cnt_base;
    logic [CW-1:0] w_cnt_nxt;

    onehot_check u_check (
        .n   (bus.n),
        .p   (bus.p),
        .idx (w_idx),
        .bad (w_bad)
    );

    assign w_accept  = bus.in_valid && w_in_ready;
    assign w_err_evt = w_accept && w_bad;

    always_ff @(posedge clk) begin
        if (rst) r_state <= EMPTY;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            EMPTY:   if (w_accept) w_state_nxt = FULL;
            FULL:    if (bus.out_ready && !w_accept) w_state_nxt = EMPTY;
            default: w_state_nxt = EMPTY;
        endcase
    end

    always_comb begin
        w_out_valid = 1'b0;
        w_in_ready  = 1'b1;
        case (r_state)
            EMPTY: begin
                w_out_valid = 1'b0;
                w_in_ready  = 1'b1;
            end
            FULL: begin
                w_out_valid = 1'b1;
                w_in_ready  = bus.out_ready;
            end
            default: begin
                w_out_valid = 1'b0;
                w_in_ready  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a        <= 1'b0;
            r_b        <= 1'b0;
            r_code_err <= 1'b0;
        end else if (w_accept) begin
            r_a        <= w_idx[1];
            r_b        <= w_idx[0];
            r_code_err <= w_bad;
        end
    end

    // Clear is applied first so an error arriving in the same cycle is still recorded.
    assign w_cnt_base = bus.clr_err ? '0 : r_err_count;
    assign w_cnt_nxt  = (w_err_evt && (w_cnt_base != CNT_MAX)) ? w_cnt_base + 1'b1 : w_cnt_base;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_count  <= '0;
            r_err_sticky <= 1'b0;
        end else begin
            r_err_count  <= w_cnt_nxt;
            r_err_sticky <= w_err_evt || (r_err_sticky && !bus.clr_err);
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = w_out_valid;
    assign bus.a          = r_a;
    assign bus.b          = r_b;
    assign bus.code_err   = r_code_err;
    assign bus.err_sticky = r_err_sticky;
    assign bus.err_count  = r_err_count;

endmodule

// File: tb/tb_decoder_2to4_encoder.sv
// Bench for the 4:2 encoder: two instances (CW=8 and CW=2) share stimulus and are compared
// against a transaction-level reference model.
module tb_decoder_2to4_encoder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       t_in_valid = 1'b0;
    logic [3:0] t_n = 4'd0;
    logic [3:0] t_p = 4'hF;
    logic       t_out_ready = 1'b1;
    logic       t_clr = 1'b0;

    decoder_2to4_encoder_if #(.CW(8)) if8 ();
    decoder_2to4_encoder_if #(.CW(2)) if2 ();

    assign if8.in_valid  = t_in_valid;
    assign if8.n         = t_n;
    assign if8.p         = t_p;
    assign if8.out_ready = t_out_ready;
    assign if8.clr_err   = t_clr;
    assign if2.in_valid  = t_in_valid;
    assign if2.n         = t_n;
    assign if2.p         = t_p;
    assign if2.out_ready = t_out_ready;
    assign if2.clr_err   = t_clr;

    decoder_2to4_encoder #(.CW(8)) u_dut8 (.clk(clk), .rst(rst), .bus(if8));
    decoder_2to4_encoder #(.CW(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    // Reference model: one output slot plus error bookkeeping, derived from the transfer rules.
    bit m_full;
    int m_idx;
    bit m_err;
    int m_cnt8, m_cnt2;
    bit m_sticky;

    function automatic int top_bit(input logic [3:0] w);
        int r = 0;
        for (int i = 0; i < 4; i++) if (w[i]) r = i;
        return r;
    endfunction

    task automatic model_edge();
        bit acc, mal;
        if (rst) begin
            m_full = 0; m_idx = 0; m_err = 0; m_cnt8 = 0; m_cnt2 = 0; m_sticky = 0;
            return;
        end
        acc = t_in_valid && (!m_full || t_out_ready);
        mal = ($countones(t_n) != 1) || (t_p !== ~t_n);
        if (acc) begin
            m_full = 1; m_idx = top_bit(t_n); m_err = mal;
        end else if (m_full && t_out_ready) begin
            m_full = 0;
        end
        if (t_clr) begin m_cnt8 = 0; m_cnt2 = 0; m_sticky = 0; end
        if (acc && mal) begin
            m_sticky = 1;
            if (m_cnt8 < 255) m_cnt8++;
            if (m_cnt2 < 3) m_cnt2++;
        end
    endtask

    task automatic check_outputs();
        chk("out_valid8", 32'(if8.out_valid), 32'(m_full));
        chk("out_valid2", 32'(if2.out_valid), 32'(m_full));
        chk("idx8", 32'({if8.a, if8.b}), 32'(m_idx));
        chk("idx2", 32'({if2.a, if2.b}), 32'(m_idx));
        chk("code_err8", 32'(if8.code_err), 32'(m_err));
        chk("err_count8", 32'(if8.err_count), 32'(m_cnt8));
        chk("err_count2", 32'(if2.err_count), 32'(m_cnt2));
        chk("err_sticky8", 32'(if8.err_sticky), 32'(m_sticky));
        chk("err_sticky2", 32'(if2.err_sticky), 32'(m_sticky));
    endtask

    // Drive one cycle of inputs, check in_ready, take the edge, then check registered outputs.
    task automatic cyc(input bit v, input logic [3:0] nn, input logic [3:0] pp,
                       input bit ordy, input bit clr, input bit r);
        t_in_valid = v; t_n = nn; t_p = pp; t_out_ready = ordy; t_clr = clr; rst = r;
        #1;
        if (!r) chk("in_ready", 32'(if8.in_ready), 32'(!m_full || ordy));
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic good(input int i, input bit ordy);
        logic [3:0] w;
        w = 4'b0001 << i;
        cyc(1, w, ~w, ordy, 0, 0);
    endtask

    initial begin
        logic [3:0] w;
        logic [3:0] q;
        cyc(0, 4'd0, 4'hF, 1, 0, 1);
        cyc(0, 4'd0, 4'hF, 1, 0, 1);
        chk("rst_out_valid", 32'(if8.out_valid), 32'd0);
        chk("rst_count", 32'(if8.err_count), 32'd0);

        // First word: 0100 -> index 2, clean.
        cyc(1, 4'b0100, 4'b1011, 1, 0, 0);
        chk("first_idx", 32'({if8.a, if8.b}), 32'd2);
        chk("first_valid", 32'(if8.out_valid), 32'd1);

        // Back-to-back stream of all four codes.
        for (int i = 0; i < 4; i++) begin
            good(i, 1);
            chk("stream_idx", 32'({if8.a, if8.b}), 32'(i));
        end
        cyc(0, 4'd0, 4'hF, 1, 0, 0);

        // Backpressure: hold 01 for five cycles while 1000 is offered.
        good(1, 1);
        for (int i = 0; i < 5; i++) begin
            cyc(1, 4'b1000, 4'b0111, 0, 0, 0);
            chk("bp_hold", 32'({if8.a, if8.b}), 32'd1);
        end
        cyc(1, 4'b1000, 4'b0111, 1, 0, 0);
        chk("bp_release", 32'({if8.a, if8.b}), 32'd3);
        cyc(0, 4'd0, 4'hF, 1, 0, 0);

        // Malformed words.
        cyc(1, 4'b0110, 4'b1001, 1, 0, 0);
        chk("mal_multi", 32'({if8.code_err, if8.a, if8.b}), 32'b110);
        cyc(1, 4'b0001, 4'b1111, 1, 0, 0);
        chk("mal_compl", 32'({if8.code_err, if8.a, if8.b}), 32'b100);
        cyc(1, 4'b0000, 4'b1111, 1, 0, 0);
        chk("mal_zero_cnt", 32'(if8.err_count), 32'd3);

        // Narrow counter saturation and clear coinciding with a new error.
        for (int i = 0; i < 5; i++) cyc(1, 4'b1100, 4'b0011, 1, 0, 0);
        chk("sat_cw2", 32'(if2.err_count), 32'd3);
        cyc(1, 4'b1100, 4'b0011, 1, 1, 0);
        chk("clr_with_err", 32'(if2.err_count), 32'd1);
        cyc(0, 4'd0, 4'hF, 1, 1, 0);
        chk("clr_alone", 32'(if8.err_sticky), 32'd0);

        // Reset while holding a word under backpressure.
        good(3, 0);
        cyc(1, 4'b0010, 4'b1101, 0, 0, 0);
        cyc(1, 4'b0010, 4'b1101, 0, 0, 1);
        chk("rst_mid_valid", 32'(if8.out_valid), 32'd0);
        chk("rst_mid_idx", 32'({if8.a, if8.b}), 32'd0);
        cyc(0, 4'd0, 4'hF, 0, 0, 0);

        // Randomized traffic.
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(9) < 7) begin
                w = 4'b0001 << $urandom_range(3);
                q = ~w;
            end else begin
                w = 4'($urandom);
                q = 4'($urandom);
            end
            cyc($urandom_range(3) != 0, w, q, $urandom_range(2) != 0,
                $urandom_range(15) == 0, $urandom_range(63) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
